// File: rtl/rop3_pkg.sv
// Shared encodings for the ROP3 request scheduler: datapath phases, scheduler
// states and the three operand-copy ROP3 codes.
package rop3_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_LOAD_P = 2'd1,
    PH_LOAD_S = 2'd2,
    PH_LOAD_D = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_P = 3'd1,
    ST_LOAD_S = 3'd2,
    ST_LOAD_D = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } sched_state_e;

  localparam logic [7:0] ROP_COPY_P = 8'hF0;
  localparam logic [7:0] ROP_COPY_S = 8'hCC;
  localparam logic [7:0] ROP_COPY_D = 8'hAA;

  localparam int TIMER_W = 4;

endpackage

// File: rtl/rop3_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer picks the winner on a tie,
// and the pointer toggles whenever the caller asks it to advance.
module rop3_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_ptr_nxt
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    o_grant   = 2'b00;
    o_ptr_nxt = i_ptr;
    if (i_req == 2'b11) begin
      o_grant = i_ptr ? 2'b10 : 2'b01;
    end else begin
      o_grant = i_req;
    end
    if (i_advance) begin
      o_ptr_nxt = ~i_ptr;
    end
  end

endmodule

// File: rtl/rop3_req_sched.sv
// Shares one ROP3 datapath between two requesters: round-robin accept, P/S/D
// phase sequencing, result capture and tagged response. Optional WAIT timeout
// is built when ROP3_SCHED_TIMEOUT_EN is defined.
module rop3_req_sched
  import rop3_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           srst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [15:0]    req_mode,
  input  logic [2*N-1:0] req_p,
  input  logic [2*N-1:0] req_s,
  input  logic [2*N-1:0] req_d,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic           rsp_err,
  output logic [1:0]     dp_phase,
  output logic [N-1:0]   dp_bitmap,
  output logic [7:0]     dp_mode,
  input  logic [N-1:0]   dp_result,
  input  logic           dp_valid
);

  if (TIMEOUT < 1 || TIMEOUT > (1 << TIMER_W)) begin : g_bad_timeout
    $error("TIMEOUT must lie in 1..16 to fit the WAIT timer");
  end

  sched_state_e r_state;
  logic         r_ptr;
  logic         r_id;
  logic [N-1:0] r_s;
  logic [N-1:0] r_d;
  logic [1:0]   w_req;
  logic [1:0]   w_grant;
  logic         w_gid;
  logic         w_accept;
  logic         w_advance;
  logic         w_ptr_nxt;

  // Grants are offered only while idle and never while reset is asserted.
  assign w_req     = (r_state == ST_IDLE && srst_n) ? req_valid : 2'b00;
  assign w_accept  = |w_grant;
  assign w_gid     = w_grant[1];
  assign w_advance = (r_state == ST_RESP) && rsp_ready;
  assign req_ready = w_grant;

  rop3_rr_arb2 u_arb (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .i_advance (w_advance),
    .o_grant   (w_grant),
    .o_ptr_nxt (w_ptr_nxt)
  );

  // NOTE: payload registers are always written on accept before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_id <= w_gid;
      r_s  <= w_gid ? req_s[2*N-1:N] : req_s[N-1:0];
      r_d  <= w_gid ? req_d[2*N-1:N] : req_d[N-1:0];
    end
  end

`ifdef ROP3_SCHED_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  logic [TIMER_W-1:0] r_timer;
  logic               r_err;
  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      dp_phase   <= PH_IDLE;
      dp_bitmap  <= '0;
      dp_mode    <= '0;
`ifdef ROP3_SCHED_TIMEOUT_EN
      r_timer    <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_LOAD_P;
            dp_phase  <= PH_LOAD_P;
            dp_bitmap <= w_gid ? req_p[2*N-1:N] : req_p[N-1:0];
            dp_mode   <= w_gid ? req_mode[15:8] : req_mode[7:0];
          end
        end
        ST_LOAD_P: begin
          r_state   <= ST_LOAD_S;
          dp_phase  <= PH_LOAD_S;
          dp_bitmap <= r_s;
        end
        ST_LOAD_S: begin
          r_state   <= ST_LOAD_D;
          dp_phase  <= PH_LOAD_D;
          dp_bitmap <= r_d;
        end
        ST_LOAD_D: begin
          r_state  <= ST_WAIT;
          dp_phase <= PH_IDLE;
        end
        ST_WAIT: begin
          if (dp_valid) begin
            r_state    <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_id     <= r_id;
            rsp_result <= dp_result;
`ifdef ROP3_SCHED_TIMEOUT_EN
            r_err      <= 1'b0;
            r_timer    <= '0;
          end else if (r_timer == TIMER_LAST) begin
            r_state    <= ST_RESP;
            rsp_valid  <= 1'b1;
            rsp_id     <= r_id;
            rsp_result <= '0;
            r_err      <= 1'b1;
            r_timer    <= '0;
          end else begin
            r_timer    <= r_timer + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state   <= ST_IDLE;
            rsp_valid <= 1'b0;
            dp_mode   <= '0;
            r_ptr     <= w_ptr_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
